seg_scan_display: RTL
=====================

Name: seg_scan_display

Overview:
- Multiplexed N-digit seven-segment driver; successor to the team's single-digit hex-to-segment decoder.
- Time-slices one shared segment bus across DIGITS common-anode digits.
- Double-buffers the displayed value so CPU-side writes never tear mid-frame.
- Adds per-digit decimal point, per-digit blanking, anti-ghosting dead time and a frame-done strobe.
- Sits between the CPU/debug register view and the board's anode and segment pins.

Parameters:
- DIGITS, 4, number of multiplexed digits; legal range 1..8.
- CLK_DIV, 100000, clock cycles per digit slot; minimum 2.
- CNT_W, $clog2(CLK_DIV), width of the slot prescaler.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- data_in  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point request per digit; 1 = lit.
- blank_in  in  DIGITS  per-digit blank; 1 = digit dark.
- load  in  1  single-cycle strobe; captures data_in, dp_in and blank_in.
- digit_en  out  DIGITS  anode selects, active low; at most one bit is 0 at any time.
- dispcode  out  8  segments {dp,g,f,e,d,c,b,a}, active low.
- frame_done  out  1  one-cycle pulse when a new frame begins.

Behaviour:
- Reset, one cycle reset=1:
  - prescaler=0, slot index=0.
  - active and pending buffers cleared to 0; pending_valid=0.
  - digit_en=all 1s, dispcode=8'hFF, frame_done=0.
- Reset mid-frame aborts the slot and discards any pending load.
- Prescaler counts 0..CLK_DIV-1 and wraps. On wrap, slot index increments mod DIGITS.
  - A slot is the CLK_DIV cycles with a given index.
  - The first slot after reset release is digit 0.
- Outputs are registered. Within a slot for digit i:
  - Prescaler==0 is the dead cycle: digit_en=all 1s, dispcode=8'hFF.
  - Prescaler 1..CLK_DIV-1: digit_en bit i=0 (others 1), dispcode=decode(active nibble i) with bit7 = ~active_dp[i].
- Blanked digit (active_blank[i]=1): digit_en stays all 1s and dispcode=8'hFF for the whole slot.
- Decode table, bit7 shown as 1 (dp off):
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:D8
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
- Load semantics:
  - load=1 writes the pending buffer and sets pending_valid. The last load within a frame wins.
  - Frame boundary = last cycle of slot DIGITS-1, i.e. prescaler==CLK_DIV-1 and index==DIGITS-1.
  - At the boundary, if pending_valid: active<=pending, pending_valid<=0.
  - load coincident with the boundary: the incoming inputs go straight to active; pending_valid<=0.
- frame_done=1 for exactly one cycle: the dead cycle of every digit-0 slot, except the first slot after reset.
- Active-buffer changes become visible from the first slot of the new frame. No partial frame ever mixes old and new values.
- DIGITS=1: every slot is a frame boundary.

Decomposition:
- Package seg_pkg holds:
  - SEG_OFF=8'hFF.
  - The 16-entry HEX_SEG constant table.
  - Slot-index width function.
- Sub-module seg7_hex_decode: combinational, 4-bit nibble plus dp flag in, 8-bit active-low code out. Instantiated once, fed by the mux of the active buffer.
- Top module holds the prescaler, slot index, buffers and output registers.

Test Plan (DIGITS=4, CLK_DIV=4):
1. Hold reset 3 cycles, then release:
   - During reset: digit_en=4'b1111, dispcode=8'hFF.
   - First frame: digit 0 shows C0 on digit_en=4'b1110 for 3 cycles per slot, with a dead cycle before each slot.
   - No frame_done in the first slot.
2. load with data_in=16'h1234 mid-frame:
   - The current frame still shows 0000.
   - After frame_done, the next frame drives digit0=99, digit1=B0, digit2=A4, digit3=F9 on digit_en 1110/1101/1011/0111.
3. dp_in=4'b0010 loaded with 16'h1234 -> digit1 dispcode=8'h30; other digits unchanged.
4. blank_in=4'b0100 -> during slot 2, digit_en=4'b1111 and dispcode=8'hFF for all 4 cycles; slots 0, 1 and 3 normal.
5. Load ordering:
   - Two loads in one frame (16'hAAAA then 16'hBEEF) -> next frame shows F, E, E, b as 8E, 86, 86, 83.
   - load exactly on the boundary cycle with 16'hC0DE -> the immediately following frame shows it.
6. Assert reset during slot 2 with a pending load outstanding:
   - Next cycle: digit_en=4'b1111, dispcode=8'hFF.
   - After release: display shows 0000; the pending value never appears.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for hex digits, dp off.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hD8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        PHASE_DEAD,
        PHASE_LIT
    } slot_phase_e;

    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment code, with decimal point.
module seg7_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] code
);

    always_comb begin
        code = {~dp, HEX_SEG[nibble][6:0]};
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed N-digit seven-segment driver with double-buffered value, blanking,
// per-digit decimal point, dead-time between digits and a frame-done strobe.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 100000,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] data_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic [DIGITS-1:0]   blank_in,
    input  logic                load,
    output logic [DIGITS-1:0]   digit_en,
    output logic [7:0]          dispcode,
    output logic                frame_done
);

    localparam int               IDX_W    = idx_width(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [IDX_W-1:0]    idx, idx_next;

    logic [4*DIGITS-1:0] act_data, act_data_next;
    logic [DIGITS-1:0]   act_dp, act_dp_next;
    logic [DIGITS-1:0]   act_blank, act_blank_next;

    logic [4*DIGITS-1:0] pend_data, pend_data_next;
    logic [DIGITS-1:0]   pend_dp, pend_dp_next;
    logic [DIGITS-1:0]   pend_blank, pend_blank_next;
    logic                pend_valid, pend_valid_next;

    logic                slot_end;
    logic                boundary;
    slot_phase_e         phase;

    logic [3:0]          nib_sel;
    logic                dp_sel;
    logic                blank_sel;
    logic [7:0]          seg_code;

    logic [DIGITS-1:0]   digit_en_next;
    logic [7:0]          dispcode_next;
    logic                frame_done_next;

    // State register: scan position, both buffers and the registered pin drivers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            digit_en   <= '1;
            dispcode   <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            idx        <= idx_next;
            act_data   <= act_data_next;
            act_dp     <= act_dp_next;
            act_blank  <= act_blank_next;
            pend_data  <= pend_data_next;
            pend_dp    <= pend_dp_next;
            pend_blank <= pend_blank_next;
            pend_valid <= pend_valid_next;
            digit_en   <= digit_en_next;
            dispcode   <= dispcode_next;
            frame_done <= frame_done_next;
        end
    end

    // Next-state: prescaler, slot index and buffer swap at the frame boundary.
    always_comb begin
        slot_end = (cnt == CNT_LAST);
        boundary = slot_end && (idx == IDX_LAST);

        cnt_next = slot_end ? '0 : cnt + CNT_W'(1);
        idx_next = idx;
        if (slot_end) begin
            idx_next = boundary ? '0 : idx + IDX_W'(1);
        end

        act_data_next   = act_data;
        act_dp_next     = act_dp;
        act_blank_next  = act_blank;
        pend_data_next  = pend_data;
        pend_dp_next    = pend_dp;
        pend_blank_next = pend_blank;
        pend_valid_next = pend_valid;

        if (boundary) begin
            // A load on the boundary cycle bypasses the pending buffer entirely.
            if (load) begin
                act_data_next  = data_in;
                act_dp_next    = dp_in;
                act_blank_next = blank_in;
            end else if (pend_valid) begin
                act_data_next  = pend_data;
                act_dp_next    = pend_dp;
                act_blank_next = pend_blank;
            end
            pend_valid_next = 1'b0;
        end else if (load) begin
            pend_data_next  = data_in;
            pend_dp_next    = dp_in;
            pend_blank_next = blank_in;
            pend_valid_next = 1'b1;
        end
    end

    // Outputs are computed from next-state so the registered pins line up with cnt/idx.
    always_comb begin
        phase     = slot_end ? PHASE_DEAD : PHASE_LIT;
        nib_sel   = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) begin
                nib_sel   = act_data_next[4*i +: 4];
                dp_sel    = act_dp_next[i];
                blank_sel = act_blank_next[i];
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (nib_sel),
        .dp     (dp_sel),
        .code   (seg_code)
    );

    always_comb begin
        digit_en_next   = '1;
        dispcode_next   = SEG_OFF;
        frame_done_next = boundary;
        if (phase == PHASE_LIT && !blank_sel) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                digit_en_next[i] = (idx_next != IDX_W'(i));
            end
            dispcode_next = seg_code;
        end
    end

endmodule
